// File: rtl/uniform_digit_checker_pkg.sv
// rtl/uniform_digit_checker_pkg.sv - shared state encoding and default parameters for the digit checker
package uniform_digit_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_SCAN    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int DEF_NUM_BINS  = 10;
   localparam int DEF_SAMPLE_W  = 4;
   localparam int DEF_COUNT_W   = 16;
   localparam int DEF_N_SAMPLES = 1000;
   localparam int DEF_TOL       = 40;

endpackage

// File: rtl/digit_bin_counter.sv
// rtl/digit_bin_counter.sv - one saturating histogram bin with synchronous clear
module digit_bin_counter #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               inc,
   output logic [COUNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + COUNT_W'(1);
      end
   end

endmodule

// File: rtl/uniform_digit_checker.sv
// rtl/uniform_digit_checker.sv - histogram-based uniformity auditor for the 0..9 digit source
module uniform_digit_checker
   import uniform_digit_checker_pkg::*;
#(
   parameter int NUM_BINS  = DEF_NUM_BINS,
   parameter int SAMPLE_W  = DEF_SAMPLE_W,
   parameter int COUNT_W   = DEF_COUNT_W,
   parameter int N_SAMPLES = DEF_N_SAMPLES,
   parameter int TOL       = DEF_TOL
) (
   input  logic                qzt_clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                range_err,
   output logic [COUNT_W-1:0]  min_count,
   output logic [COUNT_W-1:0]  max_count,
   input  logic                rd_en,
   input  logic [SAMPLE_W-1:0] rd_bin,
   output logic                rd_valid,
   output logic [COUNT_W-1:0]  rd_count
);

   state_t state, state_nxt;

   logic [COUNT_W-1:0]  counts [NUM_BINS];
   logic [NUM_BINS-1:0] hit;
   logic [COUNT_W-1:0]  sample_cnt;
   logic [SAMPLE_W-1:0] scan_idx;
   logic [COUNT_W-1:0]  scan_val;
   logic [COUNT_W-1:0]  rd_val;
   logic [COUNT_W-1:0]  min_nxt;
   logic [COUNT_W-1:0]  max_nxt;
   logic [COUNT_W-1:0]  spread;
   logic                start_acc;
   logic                accept;
   logic                last_sample;
   logic                scan_last;

   // Restart is only honoured when no run is in flight.
   assign start_acc   = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign accept      = (state == ST_COLLECT) && sample_valid;
   assign last_sample = accept && (sample_cnt == COUNT_W'(N_SAMPLES - 1));
   assign scan_last   = (state == ST_SCAN) && (scan_idx == SAMPLE_W'(NUM_BINS - 1));

   assign busy = (state == ST_COLLECT) || (state == ST_SCAN);
   assign done = (state == ST_DONE);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BINS; gi++) begin : g_bin
         assign hit[gi] = (sample == SAMPLE_W'(gi));

         digit_bin_counter #(
            .COUNT_W (COUNT_W)
         ) u_bin (
            .clk   (qzt_clk),
            .rst_n (rst_n),
            .clr   (start_acc),
            .inc   (accept && hit[gi]),
            .count (counts[gi])
         );
      end
   endgenerate

   // Index decode by compare so out-of-range read indices fall through to zero.
   always_comb begin
      scan_val = '0;
      rd_val   = '0;
      for (int i = 0; i < NUM_BINS; i++) begin
         if (scan_idx == SAMPLE_W'(i)) scan_val = counts[i];
         if (rd_bin == SAMPLE_W'(i))   rd_val   = counts[i];
      end
   end

   always_comb begin
      min_nxt = min_count;
      max_nxt = max_count;
      if ((scan_idx == '0) || (scan_val < min_count)) min_nxt = scan_val;
      if ((scan_idx == '0) || (scan_val > max_count)) max_nxt = scan_val;
      spread = max_nxt - min_nxt;
   end

   always_ff @(posedge qzt_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (start_acc)   state_nxt = ST_COLLECT;
         ST_COLLECT: if (last_sample) state_nxt = ST_SCAN;
         ST_SCAN:    if (scan_last)   state_nxt = ST_DONE;
         ST_DONE:    if (start_acc)   state_nxt = ST_COLLECT;
         default:                     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge qzt_clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt <= '0;
         range_err  <= 1'b0;
         pass       <= 1'b0;
         scan_idx   <= '0;
         min_count  <= '0;
         max_count  <= '0;
      end else begin
         if (start_acc) begin
            sample_cnt <= '0;
            range_err  <= 1'b0;
            pass       <= 1'b0;
         end else if (accept) begin
            sample_cnt <= sample_cnt + COUNT_W'(1);
            if (hit == '0) range_err <= 1'b1;
         end

         if (state == ST_SCAN) begin
            scan_idx  <= scan_idx + SAMPLE_W'(1);
            min_count <= min_nxt;
            max_count <= max_nxt;
            // The last bin's value is folded in combinationally so pass lands with DONE.
            if (scan_last) pass <= (spread <= COUNT_W'(TOL)) && !range_err;
         end else begin
            scan_idx <= '0;
         end
      end
   end

   always_ff @(posedge qzt_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_count <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_count <= rd_val;
      end
   end

endmodule

// File: tb/tb_uniform_digit_checker.sv
// tb/tb_uniform_digit_checker.sv - table-driven scoreboard bench for uniform_digit_checker
module tb_uniform_digit_checker;

   logic        qzt_clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        sample_valid;
   logic [3:0]  sample;
   logic        busy;
   logic        done;
   logic        pass;
   logic        range_err;
   logic [15:0] min_count;
   logic [15:0] max_count;
   logic        rd_en;
   logic [3:0]  rd_bin;
   logic        rd_valid;
   logic [15:0] rd_count;

   always #5 qzt_clk = ~qzt_clk;

   uniform_digit_checker dut (
      .qzt_clk      (qzt_clk),
      .rst_n        (rst_n),
      .start        (start),
      .sample_valid (sample_valid),
      .sample       (sample),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .range_err    (range_err),
      .min_count    (min_count),
      .max_count    (max_count),
      .rd_en        (rd_en),
      .rd_bin       (rd_bin),
      .rd_valid     (rd_valid),
      .rd_count     (rd_count)
   );

   typedef struct {
      int mode;
      bit gaps;
      int exp_min;
      int exp_max;
      bit exp_pass;
      bit exp_rerr;
   } vec_t;

   vec_t vecs[4];
   int   model[16];
   int   rd_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always @(posedge qzt_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge qzt_clk) begin
      if (rd_valid) begin
         if (rd_q.size() == 0) begin
            check("rd_unexpected", 1, 0);
         end else begin
            check("rd_count", int'(rd_count), rd_q.pop_front());
         end
      end
   end

   function automatic int gen(input int mode, input int n);
      if (mode == 1) return (n < 950) ? (n % 10) : 3;
      if (mode == 2) return (n == 999) ? 12 : (n % 10);
      return n % 10;
   endfunction

   task automatic clear_model();
      for (int b = 0; b < 16; b++) model[b] = 0;
   endtask

   task automatic read_bin(input int b);
      rd_en  = 1'b1;
      rd_bin = 4'(b);
      rd_q.push_back((b < 10) ? model[b] : 0);
   endtask

   task automatic read_all();
      for (int b = 0; b < 13; b++) begin
         if (b == 10 || b == 11) continue;
         @(posedge qzt_clk); #1;
         read_bin(b);
      end
      @(posedge qzt_clk); #1;
      rd_en = 1'b0;
      repeat (3) @(negedge qzt_clk);
      check("rd_drain", rd_q.size(), 0);
   endtask

   task automatic run(input vec_t v, input bit do_start);
      int  n;
      int  s;
      int  t0;
      bit  first;
      bit  got;
      if (do_start) begin
         @(posedge qzt_clk); #1;
         start = 1'b1;
         clear_model();
      end
      n = 0;
      t0 = 0;
      first = 1'b1;
      while (n < 1000) begin
         @(posedge qzt_clk); #1;
         start        = 1'b0;
         rd_en        = 1'b0;
         sample_valid = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         s            = gen(v.mode, n);
         sample       = s[3:0];
         if (sample_valid && first) begin
            t0    = cyc;
            first = 1'b0;
         end
         if (v.gaps && n == 300) start = 1'b1;
         if (sample_valid && (n == 500 || n == 999)) read_bin(s);
         if (sample_valid) begin
            if (s < 10) model[s]++;
            n++;
         end
      end
      // Samples beyond the run length must not reach the bins.
      repeat (5) begin
         @(posedge qzt_clk); #1;
         start        = 1'b0;
         rd_en        = 1'b0;
         sample_valid = 1'b1;
         sample       = 4'd0;
      end
      @(posedge qzt_clk); #1;
      sample_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge qzt_clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      check("done_seen", got, 1);
      if (!v.gaps) check("done_latency", cyc - t0, 1010);
      check("busy_done", busy, 0);
      check("min_count", int'(min_count), v.exp_min);
      check("max_count", int'(max_count), v.exp_max);
      check("pass", pass, v.exp_pass);
      check("range_err", range_err, v.exp_rerr);
      read_all();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 1'b0, 100, 100, 1'b1, 1'b0};
      vecs[1] = '{1, 1'b0,  95, 145, 1'b0, 1'b0};
      vecs[2] = '{2, 1'b0,  99, 100, 1'b0, 1'b1};
      vecs[3] = '{0, 1'b1, 100, 100, 1'b1, 1'b0};

      rst_n        = 1'b0;
      start        = 1'b0;
      sample_valid = 1'b0;
      sample       = 4'd0;
      rd_en        = 1'b0;
      rd_bin       = 4'd0;
      clear_model();
      repeat (3) @(posedge qzt_clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_range_err", range_err, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_min", int'(min_count), 0);
      check("rst_max", int'(max_count), 0);
      @(posedge qzt_clk); #1;
      rst_n = 1'b1;

      // Single read: one-cycle rd_valid pulse.
      @(posedge qzt_clk); #1;
      read_bin(3);
      @(posedge qzt_clk); #1;
      rd_en = 1'b0;
      @(negedge qzt_clk);
      check("rd_pulse_hi", rd_valid, 1);
      @(negedge qzt_clk);
      check("rd_pulse_lo", rd_valid, 0);

      // Abort mid-collect with an asynchronous reset.
      @(posedge qzt_clk); #1;
      start = 1'b1;
      @(posedge qzt_clk); #1;
      start = 1'b0;
      for (int n = 0; n < 300; n++) begin
         sample_valid = 1'b1;
         sample       = (n == 7) ? 4'd11 : 4'(n % 10);
         @(posedge qzt_clk); #1;
      end
      sample_valid = 1'b0;
      @(negedge qzt_clk);
      check("mid_busy", busy, 1);
      check("mid_range_err", range_err, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_range_err", range_err, 0);
      @(posedge qzt_clk); #1;
      rst_n = 1'b1;
      clear_model();
      read_all();

      for (int v = 0; v < 4; v++) begin
         if (v == 0) begin
            run(vecs[v], 1'b1);
         end else begin
            @(posedge qzt_clk); #1;
            start = 1'b1;
            @(posedge qzt_clk); #1;
            start = 1'b0;
            @(negedge qzt_clk);
            check("restart_done", done, 0);
            check("restart_busy", busy, 1);
            check("restart_pass", pass, 0);
            clear_model();
            read_all();
            run(vecs[v], 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
